// File: rtl/floating_point_multiply_array.sv
// LANES-wide IEEE-754 binary32 multiplier (RNE, subnormals, canonical NaN) behind an elastic
// LATENCY-stage valid/ready pipeline. Define FP_MUL_FLAGS_EN to add per-lane {overflow, invalid} flagsOut.
module floating_point_multiply_array #(
   parameter int LANES   = 4,
   parameter int LATENCY = 8
) (
   input  logic                clkIn,
   input  logic                rstIn,
   input  logic [LANES*32-1:0] dataAIn,
   input  logic [LANES*32-1:0] dataBIn,
   input  logic                modeIn,
   input  logic [LANES-1:0]    maskIn,
   input  logic                validIn,
   output logic                readyOut,
   output logic [LANES*32-1:0] dataOut,
`ifdef FP_MUL_FLAGS_EN
   output logic [LANES*2-1:0]  flagsOut,
`endif
   output logic                validOut,
   input  logic                readyIn
);

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [30:0] INF_MAG = 31'h7F80_0000;

   function automatic logic [5:0] lead_zeros(input logic [47:0] p);
      logic [5:0] n;
      n = 6'd48;
      for (int i = 0; i < 48; i++)
         if (p[i]) n = 6'(47 - i);
      return n;
   endfunction

   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic        sign, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, lost, round_up;
      logic [7:0]  ea, eb, exp_base;
      logic [47:0] prod, norm, mant;
      logic [5:0]  lz, sh;
      logic [30:0] mag;
      int          exp_r;
      sign   = a[31] ^ b[31];
      nan_a  = (&a[30:23]) && (|a[22:0]);
      nan_b  = (&b[30:23]) && (|b[22:0]);
      inf_a  = (&a[30:23]) && !(|a[22:0]);
      inf_b  = (&b[30:23]) && !(|b[22:0]);
      zero_a = !(|a[30:0]);
      zero_b = !(|b[30:0]);
      if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) return QNAN;
      if (inf_a || inf_b) return {sign, INF_MAG};
      if (zero_a || zero_b) return {sign, 31'd0};
      // Subnormals use exponent 1 with no hidden bit.
      ea    = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
      eb    = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
      prod  = {24'd0, |a[30:23], a[22:0]} * {24'd0, |b[30:23], b[22:0]};
      lz    = lead_zeros(prod);
      norm  = prod << lz;
      exp_r = int'(ea) + int'(eb) - 126 - int'(lz);
      if (exp_r >= 255) return {sign, INF_MAG};
      if (exp_r >= 1) begin
         mant     = norm;
         lost     = 1'b0;
         exp_base = 8'(exp_r - 1);
      end else begin
         sh       = (exp_r < -62) ? 6'd63 : 6'(1 - exp_r);
         mant     = norm >> sh;
         lost     = |(norm & ((48'd1 << sh) - 48'd1));
         exp_base = 8'd0;
      end
      // The hidden bit adds into the exponent field, so a rounding carry lands there naturally.
      round_up = mant[23] & ((|mant[22:0]) | lost | mant[24]);
      mag      = {exp_base, 23'd0} + {7'd0, mant[47:24]} + {30'd0, round_up};
      return {sign, mag};
   endfunction

   logic [LANES*32-1:0] prod_d;
   logic [LATENCY-1:0]  valid_q, valid_d, stage_load;
   logic [LANES*32-1:0] data_q [LATENCY];
   logic [LANES*32-1:0] data_d [LATENCY];

   always_comb begin
      prod_d = '0;
      for (int k = 0; k < LANES; k++)
         if (maskIn[k])
            prod_d[32*k +: 32] = fp_mul(dataAIn[32*k +: 32],
                                        modeIn ? dataBIn[31:0] : dataBIn[32*k +: 32]);
   end

   // A stage loads unless it and every stage downstream of it are full while the consumer stalls.
   always_comb begin
      logic chain_full;
      chain_full = 1'b1;
      stage_load = '0;
      for (int i = LATENCY - 1; i >= 0; i--) begin
         chain_full    = chain_full & valid_q[i];
         stage_load[i] = !chain_full || readyIn;
      end
   end

   // NOTE: every variable driven here gets its hold value first, so no path can infer a latch.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (stage_load[0]) begin
         valid_d[0] = validIn;
         data_d[0]  = prod_d;
      end
      for (int i = 1; i < LATENCY; i++)
         if (stage_load[i]) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
         end
   end

   // NOTE: only the valid chain is reset; payload registers are don't-care while their valid is low.
   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) valid_q <= '0;
      else       valid_q <= valid_d;
   end

   always_ff @(posedge clkIn) data_q <= data_d;

   assign readyOut = stage_load[0];
   assign validOut = valid_q[LATENCY-1];
   assign dataOut  = data_q[LATENCY-1];

`ifdef FP_MUL_FLAGS_EN
   function automatic logic [1:0] fp_flags(input logic [30:0] a, input logic [30:0] b,
                                           input logic [30:0] mag);
      logic max_a, max_b, invalid, overflow;
      max_a    = &a[30:23];
      max_b    = &b[30:23];
      invalid  = (max_a && (|a[22:0])) || (max_b && (|b[22:0])) ||
                 (max_a && !(|b)) || (max_b && !(|a));
      overflow = !max_a && !max_b && (mag == INF_MAG);
      return {overflow, invalid};
   endfunction

   logic [LANES*2-1:0] flags_in;
   logic [LANES*2-1:0] flags_q [LATENCY];
   logic [LANES*2-1:0] flags_d [LATENCY];

   always_comb begin
      flags_in = '0;
      for (int k = 0; k < LANES; k++)
         if (maskIn[k])
            flags_in[2*k +: 2] = fp_flags(dataAIn[32*k +: 31],
                                          modeIn ? dataBIn[30:0] : dataBIn[32*k +: 31],
                                          prod_d[32*k +: 31]);
   end

   always_comb begin
      flags_d = flags_q;
      if (stage_load[0]) flags_d[0] = flags_in;
      for (int i = 1; i < LATENCY; i++)
         if (stage_load[i]) flags_d[i] = flags_q[i-1];
   end

   always_ff @(posedge clkIn) flags_q <= flags_d;

   assign flagsOut = flags_q[LATENCY-1];
`endif

endmodule
